// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the divide-by-zero quotient pattern.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the partial remainder left with the
// next dividend bit, then subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;

    // The full shifted value is compared so no bit of the incoming remainder is lost.
    assign w_shift = {i_rem, i_bit};
    assign w_ge    = (w_shift >= {2'b00, i_divisor});
    assign w_sub   = w_shift[WIDTH:0] - {1'b0, i_divisor};

    assign o_qbit = w_ge;
    assign o_rem  = w_ge ? w_sub : w_shift[WIDTH:0];

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one quotient bit per cycle, MSB first, with a
// single-cycle shortcut for a zero divisor.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             zero,
    output state_e           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Handshake: a request is taken on any rising edge where start = 1 and
    // busy = 0 (IDLE or DONE); start is ignored while busy. Results are valid
    // in the single cycle done = 1 and then held until the next accepted start.

    state_e           r_state;
    state_e           w_next_state;
    logic             w_accept;
    logic             w_last;
    logic             w_qbit;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH:0]   w_step_rem;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div_by_zero;

    // r_quotient doubles as the dividend shifter: dividend bits leave at the
    // MSB while quotient bits enter at the LSB.
    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_quotient[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_qbit)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (r_state == DONE) begin
                    w_next_state = IDLE;
                end
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem         <= '0;
            r_quotient    <= '0;
            r_divisor     <= '0;
            r_cnt         <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (divisor == '0) begin
                r_quotient    <= {WIDTH{DIV0_QUOTIENT[0]}};
                r_rem         <= {1'b0, dividend};
                r_div_by_zero <= 1'b1;
            end else begin
                r_quotient    <= dividend;
                r_rem         <= '0;
                r_divisor     <= divisor;
                r_div_by_zero <= 1'b0;
            end
        end else if (r_state == RUN) begin
            r_rem      <= w_step_rem;
            r_quotient <= {r_quotient[WIDTH-2:0], w_qbit};
            r_cnt      <= r_cnt + CNT_W'(1);
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_rem[WIDTH-1:0];
    assign div_by_zero = r_div_by_zero;
    assign zero        = (r_quotient == '0);
    assign dbg_state   = r_state;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal expectations plus random
// traffic checked every cycle against an arithmetic timing/result model.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         zero;
    state_e       dbg_state;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .zero        (zero),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- model ----------------
    // An accepted request at edge e is busy after edges e..done_edge-1 and
    // shows done after edge done_edge (e+W, or e for a zero divisor).
    int           edge_cnt = 0;
    int           acc_edge = -1;
    int           done_edge = -1;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_dz = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_r[$];

    function automatic bit busy_at(int e);
        return (acc_edge >= 0) && (e >= acc_edge) && (e < done_edge);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_edge  <= -1;
            done_edge <= -1;
            m_q       <= '0;
            m_r       <= '0;
            m_dz      <= 1'b0;
            exp_q.delete();
            exp_r.delete();
        end else begin
            edge_cnt <= edge_cnt + 1;
            if (start && !busy_at(edge_cnt)) begin
                acc_edge <= edge_cnt + 1;
                if (divisor == '0) begin
                    done_edge <= edge_cnt + 1;
                    m_q       <= DIV0_QUOTIENT;
                    m_r       <= dividend;
                    m_dz      <= 1'b1;
                    exp_q.push_back(DIV0_QUOTIENT);
                    exp_r.push_back(dividend);
                end else begin
                    done_edge <= edge_cnt + 1 + W;
                    m_q       <= dividend / divisor;
                    m_r       <= dividend % divisor;
                    m_dz      <= 1'b0;
                    exp_q.push_back(dividend / divisor);
                    exp_r.push_back(dividend % divisor);
                end
            end
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, busy_at(edge_cnt));
            chk("done", done, (acc_edge >= 0) && (edge_cnt == done_edge));
            if (done && exp_q.size() > 0) begin
                chk("done_quotient", quotient, exp_q.pop_front());
                chk("done_remainder", remainder, exp_r.pop_front());
            end
            if (!busy_at(edge_cnt)) begin
                chk("hold_quotient", quotient, m_q);
                chk("hold_remainder", remainder, m_r);
                chk("hold_div_by_zero", div_by_zero, m_dz);
                chk("hold_zero", zero, m_q == '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Called at the negedge after edge `first`; reports the edge number
    // (start edge = 0) at which done is seen, or -1 on timeout.
    task automatic wait_done(input int first, output int at_edge, output bit busy_seen);
        at_edge   = -1;
        busy_seen = 1'b0;
        for (int i = first; i < first + W + 8; i++) begin
            if (busy) busy_seen = 1'b1;
            if (done) begin
                at_edge = i + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input logic z);
        chk({tag, "_quotient"}, quotient, q);
        chk({tag, "_remainder"}, remainder, r);
        chk({tag, "_div_by_zero"}, div_by_zero, dz);
        chk({tag, "_zero"}, zero, z);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  lat;
        bit  bsy;
        int  done_seen;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk_result("reset", 32'd0, 32'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        do_start(32'd100, 32'd7);
        wait_done(0, lat, bsy);
        chk("lat_100_7", lat, 33);
        chk_result("d100_7", 32'd14, 32'd2, 1'b0, 1'b0);

        do_start(32'hFFFF_FFFF, 32'd1);
        wait_done(0, lat, bsy);
        chk("lat_max_1", lat, 33);
        chk_result("dmax_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);

        do_start(32'd3, 32'd10);
        wait_done(0, lat, bsy);
        chk_result("d3_10", 32'd0, 32'd3, 1'b0, 1'b1);

        do_start(32'd5, 32'd0);
        wait_done(0, lat, bsy);
        chk("lat_div0", lat, 1);
        chk("div0_busy_seen", bsy, 1'b0);
        chk_result("d5_0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);

        // A second start while busy must be ignored.
        do_start(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, lat, bsy);
        chk("lat_ignored", lat, 33);
        chk_result("ignored", 32'd14, 32'd2, 1'b0, 1'b0);

        // Reset in the middle of a run.
        do_start(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk_result("rst_mid", 32'd0, 32'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("rst_no_done", done_seen, 0);
        do_start(32'd9, 32'd3);
        wait_done(0, lat, bsy);
        chk_result("d9_3", 32'd3, 32'd0, 1'b0, 1'b0);

        // Back-to-back: new request accepted in the DONE cycle.
        do_start(32'd100, 32'd7);
        wait_done(0, lat, bsy);
        chk_result("b2b_first", 32'd14, 32'd2, 1'b0, 1'b0);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, lat, bsy);
        chk("lat_b2b", lat, 33);
        chk_result("b2b_second", 32'd10, 32'd0, 1'b0, 1'b0);

        // Random traffic, including starts that land while busy.
        repeat (3000) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            dividend = ($urandom_range(0, 4) == 0) ? '1 : W'($urandom);
            case ($urandom_range(0, 4))
                0: divisor = '0;
                1: divisor = W'($urandom_range(1, 15));
                2: divisor = W'($urandom);
                3: divisor = dividend >> $urandom_range(0, W - 1);
                default: divisor = W'(1);
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 start  input  1  request pulse; operands are sampled on the same edge.
REQ-005 dividend  input  WIDTH  unsigned dividend.
REQ-006 divisor  input  WIDTH  unsigned divisor.
REQ-007 busy  output  1  high while an iteration sequence is running.
REQ-008 done  output  1  one-cycle pulse; results are valid in this cycle.
REQ-009 quotient  output  WIDTH  unsigned quotient.
REQ-010 remainder  output  WIDTH  unsigned remainder.
REQ-011 div_by_zero  output  1  high when the last operation had divisor == 0.
REQ-012 zero  output  1  high when quotient == 0; derived combinationally from the quotient register.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: when start = 1 and divisor != 0, latch the operands, clear the partial remainder and the iteration counter, and go to RUN.
REQ-015 IDLE: when start = 1 and divisor == 0, go directly to DONE.
- The divide-by-zero result is quotient = all-ones, remainder = dividend, div_by_zero = 1.
REQ-016 RUN: each cycle performs one restoring-division step, producing one quotient bit, MSB first.
- Step: shift the remainder left with the next dividend bit.
- If remainder >= divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
REQ-017 RUN SHALL last exactly WIDTH cycles, then go to DONE.
REQ-018 DONE SHALL last one cycle with done = 1, then go to IDLE, unless start = 1, in which case it SHALL behave as IDLE with start = 1.
REQ-019 Latency: with start sampled at edge N, done SHALL be high after edge N+WIDTH+1 for a nonzero divisor, and after edge N+1 for a zero divisor.
REQ-020 busy SHALL equal 1 exactly in RUN.
REQ-021 done SHALL equal 1 exactly in DONE.
REQ-022 start SHALL be ignored while busy = 1, with no change to operands or progress.
REQ-023 quotient, remainder, div_by_zero and zero SHALL hold their last values from DONE until the next accepted start.
REQ-024 The internal remainder SHALL be WIDTH+1 bits wide so the compare/subtract never overflows.

Reset
REQ-025 Reset asserted (rst_n = 0) SHALL immediately force state IDLE and clear busy, done, quotient, remainder, div_by_zero and the iteration counter to 0; zero SHALL then read 1.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse is produced for the aborted request.
REQ-027 After rst_n deasserts, the first accepted start SHALL follow REQ-014/REQ-015 normally.

Structure
REQ-028 A shared package SHALL hold the following, for reuse by the datapath and testbench:
- the state enum (IDLE, RUN, DONE);
- the WIDTH default;
- the DIV0_QUOTIENT all-ones constant.
REQ-029 One combinational sub-module, div_step, SHALL implement the single shift/compare/subtract step.
- Inputs: remainder, next dividend bit, divisor.
- Outputs: new remainder, quotient bit.
REQ-030 The iteration counter SHALL be sized clog2(WIDTH)+1 bits.

Verification
REQ-031 100 / 7, start at edge 0 -> done at edge 33; quotient = 14, remainder = 2, div_by_zero = 0, zero = 0.
REQ-032 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0; and 3 / 10 -> quotient = 0, remainder = 3, zero = 1.
REQ-033 5 / 0 -> done at edge 1, busy never high; quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
REQ-034 Start 100 / 7, then start 9 / 3 at edge 10 (busy) -> second request ignored; result 14 rem 2 at edge 33.
REQ-035 Start 100 / 7, rst_n low at edge 10 -> all outputs 0 immediately, no done pulse.
- After release, 9 / 3 -> quotient = 3, remainder = 0.
REQ-036 Back-to-back: start held high in the DONE cycle of 100 / 7 with operands 50 / 5 -> second done 33 cycles later; quotient = 10, remainder = 0.
